// File: rtl/x86_encoder.sv
// x86_encoder: packs one-byte-opcode + ModRM [+ SIB] [+ displacement]
// instructions into a little-endian stream of 32-bit words, one byte per cycle.
//
// state | meaning
// IDLE  | ready for a new instruction record; may start a flush of a partial word
// EMIT  | appending pending instruction bytes into the accumulator
// FLUSH | presenting a padded partial word until downstream accepts it
module x86_encoder #(
    parameter logic [7:0] PAD_BYTE = 8'h90
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_instr_valid,
    output logic        o_instr_ready,
    input  logic [7:0]  i_opcode,
    input  logic [1:0]  i_mod,
    input  logic [2:0]  i_reg,
    input  logic [2:0]  i_rm,
    input  logic [7:0]  i_sib,
    input  logic [31:0] i_disp,
    input  logic        i_flush,
    output logic [31:0] o_word,
    output logic        o_word_valid,
    input  logic        i_word_ready,
    output logic [2:0]  o_word_bytes,
    output logic [3:0]  o_instr_len
);

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_acc;
    logic [2:0]  r_cnt;
    logic [55:0] r_pend;
    logic [2:0]  r_pend_cnt;
    logic [3:0]  r_instr_len;

    logic        w_sib_req;
    logic [2:0]  w_disp_len;
    logic [31:0] w_disp_bytes;
    logic [2:0]  w_len;
    logic [55:0] w_pend;
    logic        w_hs;
    logic        w_accept;
    logic        w_append;
    logic        w_clear;
    logic [1:0]  w_lane;

    // Instruction length and byte image decoded from the presented record
    always_comb begin
        w_sib_req  = (i_mod != 2'b11) && (i_rm == 3'b100);
        w_disp_len = 3'd0;
        if (i_mod == 2'b01)
            w_disp_len = 3'd1;
        else if (i_mod == 2'b10)
            w_disp_len = 3'd4;
        else if (i_mod == 2'b00 &&
                 (i_rm == 3'b101 || (i_rm == 3'b100 && i_sib[2:0] == 3'b101)))
            w_disp_len = 3'd4;
        w_disp_bytes = 32'd0;
        if (w_disp_len == 3'd4)
            w_disp_bytes = i_disp;
        else if (w_disp_len == 3'd1)
            w_disp_bytes = {24'd0, i_disp[7:0]};
        w_len  = 3'd2 + {2'b00, w_sib_req} + w_disp_len;
        w_pend = w_sib_req ? {w_disp_bytes, i_sib, i_mod, i_reg, i_rm, i_opcode}
                           : {8'd0, w_disp_bytes, i_mod, i_reg, i_rm, i_opcode};
    end

    assign o_word_valid  = (r_cnt == 3'd4) || (r_state == FLUSH);
    assign w_hs          = o_word_valid && i_word_ready;
    assign o_instr_ready = (r_state == IDLE) && !i_reset;
    assign o_word_bytes  = r_cnt;
    assign o_instr_len   = r_instr_len;
    assign w_lane        = w_hs ? 2'd0 : r_cnt[1:0];

    // Output word: accumulator, with unused lanes padded while flushing
    always_comb begin
        o_word = r_acc;
        if (r_state == FLUSH) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) >= r_cnt)
                    o_word[8*i +: 8] = PAD_BYTE;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and datapath control
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_append = 1'b0;
        w_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_instr_valid) begin
                    w_accept = 1'b1;
                    w_next   = EMIT;
                end else if (i_flush && r_cnt != 3'd0 && r_cnt != 3'd4) begin
                    w_next = FLUSH;
                end
                // a full word left by the previous instruction drains here
                if (w_hs)
                    w_clear = 1'b1;
            end
            EMIT: begin
                if (r_cnt != 3'd4 || w_hs) begin
                    w_append = 1'b1;
                    if (r_pend_cnt == 3'd1)
                        w_next = IDLE;
                end
            end
            FLUSH: begin
                if (w_hs) begin
                    w_clear = 1'b1;
                    w_next  = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Pending-byte shifter and word accumulator
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc       <= 32'd0;
            r_cnt       <= 3'd0;
            r_pend      <= 56'd0;
            r_pend_cnt  <= 3'd0;
            r_instr_len <= 4'd0;
        end else begin
            if (w_accept) begin
                r_pend      <= w_pend;
                r_pend_cnt  <= w_len;
                r_instr_len <= {1'b0, w_len};
            end
            if (w_append) begin
                if (w_hs)
                    r_acc <= {24'd0, r_pend[7:0]};
                else
                    r_acc[{r_cnt[1:0], 3'b000} +: 8] <= r_pend[7:0];
                r_cnt      <= {1'b0, w_lane} + 3'd1;
                r_pend     <= {8'd0, r_pend[55:8]};
                r_pend_cnt <= r_pend_cnt - 3'd1;
            end else if (w_clear) begin
                r_acc <= 32'd0;
                r_cnt <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_x86_encoder.sv
// Bench for x86_encoder: directed encodings plus a randomized run against a
// byte-stream reference model.
module tb_x86_encoder;

    logic        clk;
    logic        i_reset;
    logic        i_instr_valid;
    logic        o_instr_ready;
    logic [7:0]  i_opcode;
    logic [1:0]  i_mod;
    logic [2:0]  i_reg;
    logic [2:0]  i_rm;
    logic [7:0]  i_sib;
    logic [31:0] i_disp;
    logic        i_flush;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic        i_word_ready;
    logic [2:0]  o_word_bytes;
    logic [3:0]  o_instr_len;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    bit          rand_mode = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_word = 32'd0;

    x86_encoder #(.PAD_BYTE(8'h90)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_opcode(i_opcode), .i_mod(i_mod), .i_reg(i_reg), .i_rm(i_rm),
        .i_sib(i_sib), .i_disp(i_disp), .i_flush(i_flush),
        .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
        .o_word_bytes(o_word_bytes), .o_instr_len(o_instr_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode)
            i_word_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present one record when the encoder is ready; the model appends the
    // expected byte sequence and checks the reported length.
    task automatic send(input logic [7:0] op, input logic [1:0] md, input logic [2:0] rg,
                        input logic [2:0] rm, input logic [7:0] sib, input logic [31:0] disp);
        bit got = 0;
        int dn;
        int len;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (o_instr_ready) begin
                i_opcode = op; i_mod = md; i_reg = rg; i_rm = rm;
                i_sib = sib; i_disp = disp; i_instr_valid = 1'b1;
                got = 1;
            end
            tick();
        end
        i_instr_valid = 1'b0;
        chk("send_accept", 32'(got), 32'd1);
        len = 0;
        exp_q.push_back(op);             len++;
        exp_q.push_back({md, rg, rm});   len++;
        if (md != 2'd3 && rm == 3'd4) begin
            exp_q.push_back(sib); len++;
        end
        if (md == 2'd1) dn = 1;
        else if (md == 2'd2) dn = 4;
        else if (md == 2'd0 && (rm == 3'd5 || (rm == 3'd4 && sib[2:0] == 3'd5))) dn = 4;
        else dn = 0;
        for (int i = 0; i < dn; i++) begin
            exp_q.push_back(disp[8*i +: 8]); len++;
        end
        @(negedge clk);
        chk("instr_len", 32'(o_instr_len), 32'(len));
    endtask

    task automatic do_flush();
        bit got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            if (o_instr_ready) begin
                i_flush = 1'b1;
                got = 1;
            end
            tick();
        end
        i_flush = 1'b0;
        chk("flush_idle", 32'(got), 32'd1);
    endtask

    task automatic wait_word(input string tag, input logic [31:0] w, input logic [2:0] b);
        bit got = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (o_word_valid) begin
                got = 1;
                chk(tag, o_word, w);
                chk({tag, "_bytes"}, 32'(o_word_bytes), 32'(b));
            end
            tick();
        end
        chk({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    // Word monitor: every transferred word must match the model stream, and a
    // stalled word must not change.
    always @(negedge clk) begin
        if (i_reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(o_word_valid), 32'd1);
                chk("stall_word", o_word, prev_word);
            end
            if (o_word_valid && i_word_ready) begin
                int n;
                int nb;
                logic [31:0] ew;
                n  = exp_q.size();
                nb = (n >= 4) ? 4 : n;
                ew = 32'h90909090;
                for (int i = 0; i < nb; i++) ew[8*i +: 8] = exp_q[i];
                chk("mon_nonempty", 32'(n > 0), 32'd1);
                chk("mon_word", o_word, ew);
                chk("mon_bytes", 32'(o_word_bytes), 32'(nb));
                for (int i = 0; i < nb; i++) void'(exp_q.pop_front());
            end
            prev_stall = o_word_valid && !i_word_ready;
            prev_word  = o_word;
        end
    end

    initial begin
        bit got;
        i_reset = 1'b1; i_instr_valid = 1'b0; i_flush = 1'b0; i_word_ready = 1'b1;
        i_opcode = 8'd0; i_mod = 2'd0; i_reg = 3'd0; i_rm = 3'd0; i_sib = 8'd0; i_disp = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        chk("ready_in_reset", 32'(o_instr_ready), 32'd0);
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(o_instr_ready), 32'd1);
        chk("rst_word", o_word, 32'd0);
        chk("rst_valid", 32'(o_word_valid), 32'd0);
        chk("rst_bytes", 32'(o_word_bytes), 32'd0);
        chk("rst_len", 32'(o_instr_len), 32'd0);

        // register form
        send(8'h01, 2'd3, 3'd0, 3'd3, 8'h00, 32'h0);
        chk("reg_len", 32'(o_instr_len), 32'd2);
        do_flush();
        wait_word("reg_word", 32'h9090C301, 3'd2);

        // packing across instructions
        send(8'h8B, 2'd1, 3'd0, 3'd0, 8'h00, 32'h10);
        send(8'h01, 2'd3, 3'd0, 3'd3, 8'h00, 32'h0);
        wait_word("pack_w0", 32'h0110408B, 3'd4);
        do_flush();
        wait_word("pack_w1", 32'h909090C3, 3'd1);

        // SIB + disp32
        send(8'h8B, 2'd0, 3'd0, 3'd4, 8'h25, 32'h12345678);
        chk("sib_len", 32'(o_instr_len), 32'd7);
        wait_word("sib_w0", 32'h7825048B, 3'd4);
        do_flush();
        wait_word("sib_w1", 32'h90123456, 3'd3);

        // mod10 disp32
        send(8'h8B, 2'd2, 3'd0, 3'd5, 8'h00, 32'hAABBCCDD);
        chk("m10_len", 32'(o_instr_len), 32'd6);
        wait_word("m10_w0", 32'hCCDD858B, 3'd4);
        do_flush();
        wait_word("m10_w1", 32'h9090AABB, 3'd2);

        // backpressure with a full word
        i_word_ready = 1'b0;
        send(8'h8B, 2'd0, 3'd0, 3'd4, 8'h25, 32'h12345678);
        got = 0;
        for (int c = 0; c < 50 && !got; c++) begin
            if (o_word_valid) got = 1;
            else begin tick(); @(negedge clk); end
        end
        chk("bp_full_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_word", o_word, 32'h7825048B);
            chk("bp_ready", 32'(o_instr_ready), 32'd0);
            tick();
            @(negedge clk);
        end
        tick();
        i_word_ready = 1'b1;
        wait_word("bp_w0", 32'h7825048B, 3'd4);
        do_flush();
        wait_word("bp_w1", 32'h90123456, 3'd3);

        // reset one cycle into EMIT
        send(8'h8B, 2'd0, 3'd0, 3'd4, 8'h25, 32'h12345678);
        tick();
        i_reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_ready", 32'(o_instr_ready), 32'd0);
        tick();
        i_reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_word", o_word, 32'd0);
        chk("mid_rst_valid", 32'(o_word_valid), 32'd0);
        chk("mid_rst_bytes", 32'(o_word_bytes), 32'd0);
        chk("mid_rst_len", 32'(o_instr_len), 32'd0);
        chk("mid_rst_ready1", 32'(o_instr_ready), 32'd1);
        do_flush();
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (o_word_valid) got = 1;
            tick();
        end
        chk("mid_rst_no_word", 32'(got), 32'd0);

        // randomized stream with random downstream stalls and flushes
        rand_mode = 1;
        for (int n = 0; n < 150; n++) begin
            send(8'($urandom), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom), $urandom);
            if ($urandom_range(0, 7) == 0) do_flush();
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_mode = 0;
        i_word_ready = 1'b1;
        do_flush();
        for (int c = 0; c < 200 && (exp_q.size() != 0 || o_word_valid); c++) tick();
        @(negedge clk);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(o_word_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x86_encoder.md
X86_ENCODER -- requirements
Module: x86_encoder

Interface
REQ-001 Parameter PAD_BYTE, default 8'h90, SHALL be the filler byte used in unused lanes of a flushed partial word.
REQ-002 i_clk  input  1  SHALL be the clock; all state changes on the rising edge.
REQ-003 i_reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 i_instr_valid  input  1  SHALL indicate an instruction record is presented.
REQ-005 o_instr_ready  output  1  SHALL indicate the record is accepted on this edge when i_instr_valid is also high.
REQ-006 i_opcode  input  8  SHALL be the one-byte opcode.
REQ-007 i_mod, i_reg, i_rm  input  2/3/3  SHALL be the ModRM fields; ModRM byte = {i_mod,i_reg,i_rm}.
REQ-008 i_sib  input  8  SHALL be the SIB byte, used only when a SIB is required (REQ-014).
REQ-009 i_disp  input  32  SHALL be the displacement; disp8 uses i_disp[7:0].
REQ-010 i_flush  input  1  SHALL request emission of a partial word.
REQ-011 o_word  output  32  SHALL be the packed little-endian output word; first byte in [7:0].
REQ-012 o_word_valid  output  1  SHALL qualify o_word; the word transfers on an edge where o_word_valid and i_word_ready are both high.
REQ-013 i_word_ready  input  1  SHALL be downstream acceptance; o_word_bytes output 3 SHALL give valid byte count (1..4); o_instr_len output 4 SHALL give the byte length of the last accepted instruction.

Function
REQ-014 Length: opcode 1 + ModRM 1, plus SIB 1 when mod!=11 and rm==100, plus displacement: mod00,rm101 -> 4; mod00,rm100,sib[2:0]==101 -> 4; mod01 -> 1; mod10 -> 4; otherwise 0. Maximum length is 7.
REQ-015 Byte order SHALL be opcode, ModRM, [SIB], [displacement LSB first].
REQ-016 States SHALL be IDLE, EMIT and FLUSH; o_instr_ready SHALL be 1 only in IDLE with i_reset low.
REQ-017 Accept (IDLE, i_instr_valid=1): the block SHALL latch the bytes and length, set o_instr_len, and go to EMIT.
REQ-018 EMIT: on each cycle where accumulator count <4, or a word handshake occurs, the block SHALL append exactly one pending byte at lane = count (0 after a handshake).
REQ-019 When the accumulator count reaches 4, o_word_valid SHALL assert on the next cycle with o_word_bytes=4 and SHALL hold with o_word stable until handshake.
REQ-020 After the last byte is appended, the block SHALL return to IDLE on the next cycle; leftover bytes (count 1..3) SHALL stay in the accumulator for the next instruction.
REQ-021 Backpressure: while o_word_valid=1 and i_word_ready=0, no byte SHALL be appended and no state SHALL change.
REQ-022 Flush: in IDLE with i_flush=1, i_instr_valid=0 and count 1..3, the block SHALL enter FLUSH, drive o_word_valid=1, fill unused lanes with PAD_BYTE, set o_word_bytes=count, and on handshake clear count and return to IDLE.
REQ-023 i_flush SHALL be ignored when count==0, outside IDLE, or when i_instr_valid=1 in the same cycle, where the instruction wins.
REQ-024 i_sib and i_disp SHALL be ignored when not required by REQ-014; an illegal combination SHALL NOT exist, since all 256 ModRM values are encodable.

Reset
REQ-025 With i_reset=1 at an edge, the state SHALL go to IDLE, the accumulator and pending bytes SHALL clear, and o_word_valid=0, o_word=0, o_word_bytes=0, o_instr_len=0.
REQ-026 o_instr_ready SHALL be 0 while i_reset is high and 1 on the first cycle after deassertion.
REQ-027 Reset mid-EMIT or mid-FLUSH SHALL discard all bytes, with no partial word emitted afterwards.

Verification
REQ-028 Register form: op 01, mod11 reg000 rm011, then flush -> o_instr_len=2, o_word=0x9090C301, o_word_bytes=2.
REQ-029 Packing: 8B/mod01 reg000 rm000/disp 0x10, then 01/C3, then flush -> 0x0110408B (bytes 4), then 0x909090C3 (bytes 1).
REQ-030 SIB+disp32: 8B, ModRM 04, SIB 25, disp 0x12345678, then flush -> len 7, 0x7825048B, then 0x90123456 (bytes 3).
REQ-031 mod10: 8B, ModRM 85, disp 0xAABBCCDD -> len 6, first word 0xCCDD858B, with bytes BB AA pending.
REQ-032 Backpressure: hold i_word_ready=0 for 5 cycles with a full word -> o_word stable, o_instr_ready=0, no byte loss after release.
REQ-033 Reset pulse one cycle into EMIT of REQ-030 -> all outputs 0 on the next cycle, o_instr_ready=1 after, and a following flush emits nothing.
